// File: rtl/hilo_acc_reg.sv
// HI/LO register pair: per-half and full writes and clear commit 1 cycle after accept; MADD/MSUB
// commit both halves 2 cycles after accept. ready_o drops for one cycle while an accumulate is in flight.
module hilo_acc_reg #(
  parameter int DW     = 32,
  parameter bit ACC_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [2:0]    op_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  output logic          ready_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          done_o
);

  localparam logic [2:0] OP_WR_HI   = 3'd1;
  localparam logic [2:0] OP_WR_LO   = 3'd2;
  localparam logic [2:0] OP_WR_BOTH = 3'd3;
  localparam logic [2:0] OP_MADD    = 3'd4;
  localparam logic [2:0] OP_MSUB    = 3'd5;
  localparam logic [2:0] OP_CLR     = 3'd6;

  typedef enum logic {IDLE, ACC_HI} state_t;

  state_t        state;
  logic          carry;
  logic          acc_sub;
  logic [DW-1:0] lo_tmp;
  logic [DW-1:0] hi_opnd;

  logic          accept;
  logic          req_sub;
  logic [DW:0]   lo_sum;
  logic [DW-1:0] hi_sum;

  assign ready_o = (state == IDLE);
  assign accept  = valid_i & ready_o;
  assign req_sub = (op_i == OP_MSUB);

  // Subtraction is two's-complement add: invert the operand, carry-in of 1 on the low half only.
  assign lo_sum = {1'b0, lo_o} + {1'b0, (req_sub ? ~lo_i : lo_i)} + {{DW{1'b0}}, req_sub};
  assign hi_sum = hi_o + (acc_sub ? ~hi_opnd : hi_opnd) + {{(DW-1){1'b0}}, carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hi_o    <= '0;
      lo_o    <= '0;
      done_o  <= 1'b0;
      carry   <= 1'b0;
      acc_sub <= 1'b0;
      lo_tmp  <= '0;
      hi_opnd <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_i)
              OP_WR_HI: begin
                hi_o   <= hi_i;
                done_o <= 1'b1;
              end
              OP_WR_LO: begin
                lo_o   <= lo_i;
                done_o <= 1'b1;
              end
              OP_WR_BOTH: begin
                hi_o   <= hi_i;
                lo_o   <= lo_i;
                done_o <= 1'b1;
              end
              OP_CLR: begin
                hi_o   <= '0;
                lo_o   <= '0;
                done_o <= 1'b1;
              end
              OP_MADD, OP_MSUB: begin
                if (ACC_EN) begin
                  // Low half is staged, not committed, so no partial result is ever visible.
                  {carry, lo_tmp} <= lo_sum;
                  hi_opnd         <= hi_i;
                  acc_sub         <= req_sub;
                  state           <= ACC_HI;
                end
              end
              default: ;
            endcase
          end
        end
        ACC_HI: begin
          hi_o   <= hi_sum;
          lo_o   <= lo_tmp;
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_acc_reg.sv
// Directed bench for hilo_acc_reg: a 64-bit model predicts each commit, the monitor pops on done_o.
module tb_hilo_acc_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] hi_in = '0;
  logic [31:0] lo_in = '0;
  logic        ready_o, done_o;
  logic [31:0] hi_o, lo_o;

  logic        valid0 = 1'b0;
  logic [2:0]  op0 = 3'd0;
  logic [31:0] hi_in0 = '0;
  logic [31:0] lo_in0 = '0;
  logic        ready0, done0;
  logic [31:0] hi0, lo0;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic [63:0] model = '0;

  always #5 clk = ~clk;

  hilo_acc_reg #(.DW(32), .ACC_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .valid_i(valid), .op_i(op), .hi_i(hi_in), .lo_i(lo_in),
    .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o), .done_o(done_o)
  );

  hilo_acc_reg #(.DW(32), .ACC_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .valid_i(valid0), .op_i(op0), .hi_i(hi_in0), .lo_i(lo_in0),
    .ready_o(ready0), .hi_o(hi0), .lo_o(lo0), .done_o(done0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every done_o pulse must match the oldest predicted commit.
  always begin
    @(posedge clk);
    #1;
    if (done_o) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", {63'd0, done_o}, 64'd0);
      end else begin
        chk("commit_value", {hi_o, lo_o}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_q();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Drives a request, holds it until accepted, then predicts the commit.
  task automatic issue(input logic [2:0] o, input logic [31:0] h, input logic [31:0] l,
                       input bit wait_done);
    int n = 0;
    valid = 1'b1;
    op    = o;
    hi_in = h;
    lo_in = l;
    while (!ready_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready_o) chk("ready_timeout", {63'd0, ready_o}, 64'd1);
    @(posedge clk);
    case (o)
      3'd1: begin model[63:32] = h; exp_q.push_back(model); end
      3'd2: begin model[31:0] = l;  exp_q.push_back(model); end
      3'd3: begin model = {h, l};   exp_q.push_back(model); end
      3'd4: begin model = model + {h, l}; exp_q.push_back(model); end
      3'd5: begin model = model - {h, l}; exp_q.push_back(model); end
      3'd6: begin model = '0;       exp_q.push_back(model); end
      default: ;
    endcase
    #1;
    valid = 1'b0;
    op    = 3'd0;
    if (wait_done) wait_q();
  endtask

  initial begin
    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    chk("rst_ready_acc0", {63'd0, ready0}, 64'd1);

    // 2: full and per-half writes
    issue(3'd3, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    issue(3'd1, 32'hFFFF0000, 32'h0, 1'b1);
    chk("wr_hi_keeps_lo", {hi_o, lo_o}, 64'hFFFF0000_9ABCDEF0);
    issue(3'd2, 32'h0, 32'h0BADF00D, 1'b1);
    issue(3'd0, 32'h1, 32'h1, 1'b1);
    issue(3'd7, 32'h2, 32'h2, 1'b1);
    @(posedge clk);
    #1;
    chk("nop_no_change", {hi_o, lo_o}, 64'hFFFF0000_0BADF00D);

    // 3: MADD carry from LO into HI, 2-cycle commit
    issue(3'd3, 32'h0, 32'hFFFFFFFF, 1'b1);
    issue(3'd4, 32'h0, 32'h1, 1'b0);
    chk("madd_busy", {63'd0, ready_o}, 64'd0);
    chk("madd_no_partial", {hi_o, lo_o}, 64'h00000000_FFFFFFFF);
    chk("madd_no_early_done", {63'd0, done_o}, 64'd0);
    wait_q();
    chk("madd_result", {hi_o, lo_o}, 64'h00000001_00000000);
    chk("madd_ready_back", {63'd0, ready_o}, 64'd1);

    // 4: wrap-around both ways, plus borrow across halves
    issue(3'd6, 32'h0, 32'h0, 1'b1);
    issue(3'd5, 32'h0, 32'h1, 1'b1);
    chk("msub_wrap", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFF);
    issue(3'd4, 32'h0, 32'h1, 1'b1);
    chk("madd_wrap", {hi_o, lo_o}, 64'd0);
    issue(3'd3, 32'h00000001, 32'h00000000, 1'b1);
    issue(3'd5, 32'h0, 32'h1, 1'b1);
    issue(3'd4, 32'h80000000, 32'h80000001, 1'b1);
    issue(3'd5, 32'h12345678, 32'hFFFFFFFF, 1'b1);

    // 5a: reset aborts an in-flight accumulate
    issue(3'd3, 32'h5, 32'h6, 1'b1);
    issue(3'd4, 32'h1, 32'h1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model = '0;
    chk("abort_hilo", {hi_o, lo_o}, 64'd0);
    chk("abort_done", {63'd0, done_o}, 64'd0);
    chk("abort_ready", {63'd0, ready_o}, 64'd1);

    // 5b: WR_LO held while busy lands after the accumulate
    issue(3'd3, 32'h1, 32'h2, 1'b1);
    issue(3'd4, 32'h3, 32'h4, 1'b0);
    issue(3'd2, 32'h0, 32'hAAAA5555, 1'b1);
    chk("held_wr_lo", {hi_o, lo_o}, 64'h00000004_AAAA5555);

    // 6: ACC_EN=0 treats MADD as NOP
    valid0 = 1'b1; op0 = 3'd3; hi_in0 = 32'h7; lo_in0 = 32'h8;
    @(posedge clk);
    #1;
    chk("acc0_wr_done", {63'd0, done0}, 64'd1);
    chk("acc0_wr_val", {hi0, lo0}, 64'h00000007_00000008);
    op0 = 3'd4; hi_in0 = 32'h5; lo_in0 = 32'h5;
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    chk("acc0_ready", {63'd0, ready0}, 64'd1);
    chk("acc0_no_done", {63'd0, done0}, 64'd0);
    @(posedge clk);
    #1;
    chk("acc0_no_done2", {63'd0, done0}, 64'd0);
    chk("acc0_unchanged", {hi0, lo0}, 64'h00000007_00000008);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
